// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the fifo_ctrl block and its pointer counter.
package fifo_pkg;

    localparam int FIFO_DATA_DEF     = 16;
    localparam int FIFO_ADDR_DEF     = 5;
    localparam int FIFO_DEPTH_DEF    = 32'd2 ** FIFO_ADDR_DEF;
    localparam int FIFO_AE_LEVEL_DEF = 2;

    // One extra pointer bit distinguishes full from empty when the low bits match.
    function automatic int fifo_ptr_w(input int addr);
        return addr + 32'd1;
    endfunction

    function automatic int fifo_depth(input int addr);
        return 32'd2 ** addr;
    endfunction

    function automatic int fifo_af_level_def(input int addr);
        return fifo_depth(addr) - 32'd2;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment enable and synchronous active-high reset.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int W = fifo_ptr_w(FIFO_ADDR_DEF)
) (
    input  logic         clK,
    input  logic         rsT,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register; natural binary overflow gives the modulo-2**W wrap.
    always_ff @(posedge clK) begin
        if (rsT) begin
            ptr_r <= {W{1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM (A = write, B = read).
// Optional almost_full/almost_empty flags are built when FIFO_ALMOST_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA     = FIFO_DATA_DEF,
    parameter int ADDR     = FIFO_ADDR_DEF,
    parameter int AF_LEVEL = fifo_af_level_def(ADDR),
    parameter int AE_LEVEL = FIFO_AE_LEVEL_DEF
) (
    input  logic            clK,
    input  logic            rsT,
    input  logic            wr_EN,
    input  logic [DATA-1:0] wr_data_IN,
    input  logic            rd_EN,
    output logic [DATA-1:0] rd_data_OUT,
    output logic            rd_VALID,
    output logic            full,
    output logic            empty,
    output logic [ADDR:0]   count,
    output logic            wr_ERR,
    output logic            rd_ERR,
`ifdef FIFO_ALMOST_EN
    output logic            almost_full,
    output logic            almost_empty,
`endif
    output logic            a_port_WR,
    output logic [ADDR-1:0] a_port_ADDR,
    output logic [DATA-1:0] a_port_data_IN,
    output logic            b_port_WR,
    output logic [ADDR-1:0] b_port_ADDR,
    output logic [DATA-1:0] b_port_data_IN,
    input  logic [DATA-1:0] b_port_data_OUT
);

    localparam int PW    = fifo_ptr_w(ADDR);
    localparam int DEPTH = fifo_depth(ADDR);

    if ((AE_LEVEL > AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
        $error("fifo_ctrl: AE_LEVEL/AF_LEVEL out of range");
    end

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_nxt_s;
    logic [PW-1:0] rd_nxt_s;
    logic [PW-1:0] cnt_nxt_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          full_nxt_s;
    logic          empty_nxt_s;

    logic          full_r;
    logic          empty_r;
    logic [PW-1:0] count_r;
    logic          rd_valid_r;
    logic          wr_err_r;
    logic          rd_err_r;

    // Acceptance looks only at registered flags, so a push never bypasses into a same-cycle pop.
    assign wr_acc_s = wr_EN & ~full_r  & ~rsT;
    assign rd_acc_s = rd_EN & ~empty_r & ~rsT;

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clK (clK),
        .rsT (rsT),
        .inc (wr_acc_s),
        .ptr (wr_ptr_s)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clK (clK),
        .rsT (rsT),
        .inc (rd_acc_s),
        .ptr (rd_ptr_s)
    );

    // Post-edge pointer values, from which the registered status is derived.
    always_comb begin
        wr_nxt_s    = wr_ptr_s + {{ADDR{1'b0}}, wr_acc_s};
        rd_nxt_s    = rd_ptr_s + {{ADDR{1'b0}}, rd_acc_s};
        cnt_nxt_s   = wr_nxt_s - rd_nxt_s;
        empty_nxt_s = (wr_nxt_s == rd_nxt_s);
        full_nxt_s  = (wr_nxt_s[ADDR-1:0] == rd_nxt_s[ADDR-1:0]) &&
                      (wr_nxt_s[ADDR] != rd_nxt_s[ADDR]);
    end

    // Status and strobe registers, updated on the same edge as the pointers.
    always_ff @(posedge clK) begin
        if (rsT) begin
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            count_r    <= {PW{1'b0}};
            rd_valid_r <= 1'b0;
            wr_err_r   <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            full_r     <= full_nxt_s;
            empty_r    <= empty_nxt_s;
            count_r    <= cnt_nxt_s;
            rd_valid_r <= rd_acc_s;
            wr_err_r   <= wr_EN & full_r;
            rd_err_r   <= rd_EN & empty_r;
        end
    end

`ifdef FIFO_ALMOST_EN
    localparam logic [PW-1:0] AF_LVL_C = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL_C = PW'(AE_LEVEL);

    logic almost_full_r;
    logic almost_empty_r;

    // Threshold flags follow the next occupancy so they align with count.
    always_ff @(posedge clK) begin
        if (rsT) begin
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            almost_full_r  <= (cnt_nxt_s >= AF_LVL_C);
            almost_empty_r <= (cnt_nxt_s <= AE_LVL_C);
        end
    end

    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
`endif

    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign rd_VALID = rd_valid_r;
    assign wr_ERR   = wr_err_r;
    assign rd_ERR   = rd_err_r;

    // RAM controls are combinational so the write and read land on the pointer edge.
    assign a_port_WR      = wr_acc_s;
    assign a_port_ADDR    = wr_ptr_s[ADDR-1:0];
    assign a_port_data_IN = wr_data_IN;
    assign b_port_WR      = 1'b0;
    assign b_port_ADDR    = rd_ptr_s[ADDR-1:0];
    assign b_port_data_IN = {DATA{1'b0}};
    assign rd_data_OUT    = b_port_data_OUT;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (depth 4): directed scenarios then random traffic against a queue model.
module tb_fifo_ctrl;

    localparam int DATA  = 16;
    localparam int ADDR  = 2;
    localparam int DEPTH = 4;

    logic            clK = 1'b0;
    logic            rsT;
    logic            wr_EN;
    logic [DATA-1:0] wr_data_IN;
    logic            rd_EN;
    logic [DATA-1:0] rd_data_OUT;
    logic            rd_VALID;
    logic            full;
    logic            empty;
    logic [ADDR:0]   count;
    logic            wr_ERR;
    logic            rd_ERR;
`ifdef FIFO_ALMOST_EN
    logic            almost_full;
    logic            almost_empty;
`endif
    logic            a_port_WR;
    logic [ADDR-1:0] a_port_ADDR;
    logic [DATA-1:0] a_port_data_IN;
    logic            b_port_WR;
    logic [ADDR-1:0] b_port_ADDR;
    logic [DATA-1:0] b_port_data_IN;
    logic [DATA-1:0] b_port_data_OUT;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clK = ~clK;

    fifo_ctrl #(.DATA(DATA), .ADDR(ADDR), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clK             (clK),
        .rsT             (rsT),
        .wr_EN           (wr_EN),
        .wr_data_IN      (wr_data_IN),
        .rd_EN           (rd_EN),
        .rd_data_OUT     (rd_data_OUT),
        .rd_VALID        (rd_VALID),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .wr_ERR          (wr_ERR),
        .rd_ERR          (rd_ERR),
`ifdef FIFO_ALMOST_EN
        .almost_full     (almost_full),
        .almost_empty    (almost_empty),
`endif
        .a_port_WR       (a_port_WR),
        .a_port_ADDR     (a_port_ADDR),
        .a_port_data_IN  (a_port_data_IN),
        .b_port_WR       (b_port_WR),
        .b_port_ADDR     (b_port_ADDR),
        .b_port_data_IN  (b_port_data_IN),
        .b_port_data_OUT (b_port_data_OUT)
    );

    // Behavioural dual-port RAM: write on A, registered read on B.
    logic [DATA-1:0] ram [0:DEPTH-1];
    always @(posedge clK) begin
        if (a_port_WR) ram[a_port_ADDR] <= a_port_data_IN;
        b_port_data_OUT <= ram[b_port_ADDR];
    end

    // Reference model: a plain queue with capacity DEPTH.
    logic [DATA-1:0] q[$];
    logic            e_valid;
    logic [DATA-1:0] e_data;
    logic            e_werr;
    logic            e_rerr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic rd, input logic [DATA-1:0] d);
        bit m_full;
        bit m_empty;
        @(negedge clK);
        rsT = rst; wr_EN = wr; rd_EN = rd; wr_data_IN = d;
        #1;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        check_val("a_port_WR", {31'd0, a_port_WR}, {31'd0, (wr && !m_full && !rst)});
        check_val("a_port_data_IN", {16'd0, a_port_data_IN}, {16'd0, d});
        @(posedge clK);
        if (rst) begin
            q.delete();
            e_valid = 1'b0; e_werr = 1'b0; e_rerr = 1'b0;
        end else begin
            e_werr  = wr && m_full;
            e_rerr  = rd && m_empty;
            e_valid = rd && !m_empty;
            if (rd && !m_empty) e_data = q.pop_front();
            if (wr && !m_full) q.push_back(d);
        end
        #1;
        check_val("count", {29'd0, count}, q.size());
        check_val("full", {31'd0, full}, {31'd0, (q.size() == DEPTH)});
        check_val("empty", {31'd0, empty}, {31'd0, (q.size() == 0)});
        check_val("rd_VALID", {31'd0, rd_VALID}, {31'd0, e_valid});
        check_val("wr_ERR", {31'd0, wr_ERR}, {31'd0, e_werr});
        check_val("rd_ERR", {31'd0, rd_ERR}, {31'd0, e_rerr});
        if (e_valid) check_val("rd_data_OUT", {16'd0, rd_data_OUT}, {16'd0, e_data});
`ifdef FIFO_ALMOST_EN
        check_val("almost_full", {31'd0, almost_full}, {31'd0, (q.size() >= 3)});
        check_val("almost_empty", {31'd0, almost_empty}, {31'd0, (q.size() <= 1)});
`endif
    endtask

    initial begin
        logic [DATA-1:0] seq;
        rsT = 1'b1; wr_EN = 1'b0; rd_EN = 1'b0; wr_data_IN = 16'h0000;
        e_valid = 1'b0; e_data = 16'h0000; e_werr = 1'b0; e_rerr = 1'b0;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_val("b_port_WR", {31'd0, b_port_WR}, 32'd0);
        check_val("b_port_data_IN", {16'd0, b_port_data_IN}, 32'd0);

        // Fill, then overflow push
        step(1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h3333);
        step(1'b0, 1'b1, 1'b0, 16'h4444);
        step(1'b0, 1'b1, 1'b0, 16'h5555);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Drain back-to-back, then underflow pop
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);

        // Steady push+pop at count 2, wrapping the pointers
        step(1'b0, 1'b1, 1'b0, 16'hA000);
        step(1'b0, 1'b1, 1'b0, 16'hA001);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 16'hB000 + 16'(i));
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0000);

        // Push+pop while empty, then pop the pushed word
        step(1'b0, 1'b1, 1'b1, 16'hBEEF);
        step(1'b0, 1'b0, 1'b1, 16'h0000);

        // Reset at count 3 with a push pending
        step(1'b0, 1'b1, 1'b0, 16'hC001);
        step(1'b0, 1'b1, 1'b0, 16'hC002);
        step(1'b0, 1'b1, 1'b0, 16'hC003);
        step(1'b1, 1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b0, 1'b1, 16'h0000);

        // Random traffic with alternating fill/drain bias and rare resets
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            seq  = 16'($urandom);
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < bias),
                 ($urandom_range(0, 99) < (100 - bias)),
                 seq);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
